// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-stage request and HI/LO result bundle for muldiv_sequencer
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, rs, rt, flush, input stall, busy, done, err, hi, lo);
  modport slave (input start, op, rs, rt, flush, output stall, busy, done, err, hi, lo);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-cycle iterative MULT/MULTU into HI/LO; DIV/DIVU added when MULDIV_DIVIDE_EN is defined
module muldiv_sequencer (
  input logic               clk,
  input logic               rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, step, fixed;
  logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, abs_rs, abs_rt;
  logic        neg_q, neg_d, err_q, err_d, bad;
  logic [32:0] add;
`ifdef MULDIV_DIVIDE_EN
  logic        div_q, div_d, rneg_q, rneg_d;
  logic [32:0] trial;
`endif
  assign abs_rs = (bus.op[0] && bus.rs[31]) ? -bus.rs : bus.rs;
  assign abs_rt = (bus.op[0] && bus.rt[31]) ? -bus.rt : bus.rt;
  // multiplier sits in acc low half and shifts out as the product shifts in
  assign add = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
`ifdef MULDIV_DIVIDE_EN
  // restoring divide: acc = {remainder, dividend/quotient}, trial borrow means restore
  assign trial = acc_q[63:31] - {1'b0, m_q};
  assign bad   = bus.op[1] && bus.rt == 32'd0;
  assign step  = !div_q ? {add, acc_q[31:1]} :
                 trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
  assign fixed = !div_q ? (neg_q ? -acc_q : acc_q) :
                 {rneg_q ? -acc_q[63:32] : acc_q[63:32], neg_q ? -acc_q[31:0] : acc_q[31:0]};
`else
  assign bad   = bus.op[1];
  assign step  = {add, acc_q[31:1]};
  assign fixed = neg_q ? -acc_q : acc_q;
`endif
  assign bus.busy  = state_q == RUN || state_q == FIX;
  assign bus.done  = state_q == DONE;
  assign bus.err   = state_q == DONE && err_q;
  assign bus.stall = state_q == RUN || state_q == FIX || (state_q == IDLE && bus.start && !bus.flush);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  // sequencing: accept in IDLE, 32 iterations in RUN, sign fix and HI/LO write in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    err_d   = err_q;
`ifdef MULDIV_DIVIDE_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
`endif
    if (bus.flush) state_d = IDLE;
    else if (state_q == IDLE && bus.start) begin
      state_d = bad ? DONE : RUN;
      err_d   = bad;
      cnt_d   = 5'd0;
      acc_d   = {32'd0, bus.op[1] ? abs_rs : abs_rt};
      m_d     = bus.op[1] ? abs_rt : abs_rs;
      neg_d   = bus.op[0] && (bus.rs[31] ^ bus.rt[31]);
`ifdef MULDIV_DIVIDE_EN
      div_d   = bus.op[1];
      rneg_d  = bus.op[0] && bus.rs[31];
`endif
    end else if (state_q == RUN) begin
      acc_d   = step;
      cnt_d   = cnt_q + 5'd1;
      state_d = cnt_q == 5'd31 ? FIX : RUN;
    end else if (state_q == FIX) begin
      hi_d    = fixed[63:32];
      lo_d    = fixed[31:0];
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
  end
  // state registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      m_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
`ifdef MULDIV_DIVIDE_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
`endif
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer with directed vectors
module tb_muldiv_sequencer;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        e_mon;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_sequencer_if b();
  muldiv_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every done pops one expectation; err must stay low outside done
  always @(negedge clk) begin
    if (b.done === 1'b1) begin
      if (sb.size() == 0) check("unexpected_done", 32'(b.done), 32'd0);
      else begin
        e_mon = sb.pop_front();
        check("hi", b.hi, e_mon.hi);
        check("lo", b.lo, e_mon.lo);
        check("err", 32'(b.err), 32'(e_mon.err));
        check("latency", 32'(cyc - e_mon.t0), 32'(e_mon.lat));
      end
    end else if (rst_n) check("err_without_done", 32'(b.err), 32'd0);
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] eh, input logic [31:0] el, input logic ee,
                       input int lat, input bit push);
    @(negedge clk);
    b.start = 1'b1;
    b.op = op;
    b.rs = rs;
    b.rt = rt;
    if (push) begin
      sb.push_back('{hi: eh, lo: el, err: ee, t0: cyc, lat: lat});
      if (!ee) begin
        m_hi = eh;
        m_lo = el;
      end
    end
    #1 check("stall_on_start", 32'(b.stall), 32'd1);
    @(negedge clk);
    b.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] eh, input logic [31:0] el);
    issue(op, rs, rt, eh, el, 1'b0, 34, 1'b1);
    drain(60);
  endtask

  task automatic run_err(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    issue(op, rs, rt, m_hi, m_lo, 1'b1, 1, 1'b1);
    drain(10);
  endtask

  initial begin
    b.start = 1'b0;
    b.flush = 1'b0;
    b.op = 2'b00;
    b.rs = 32'd0;
    b.rt = 32'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_hi", b.hi, 32'd0);
    check("rst_lo", b.lo, 32'd0);
    check("rst_busy", 32'(b.busy), 32'd0);
    check("rst_done", 32'(b.done), 32'd0);
    check("rst_err", 32'(b.err), 32'd0);
    check("rst_stall", 32'(b.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    run(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run(2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001);
    run(2'b01, 32'd0, 32'hFFFFFFFB, 32'd0, 32'd0);
    run(2'b00, 32'h80000000, 32'd2, 32'd1, 32'd0);
`ifdef MULDIV_DIVIDE_EN
    run(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run(2'b10, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF);
    run(2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    run_err(2'b11, 32'h00001234, 32'd0);
    run_err(2'b10, 32'd5, 32'd0);
`else
    run_err(2'b10, 32'd100, 32'd7);
    run_err(2'b11, 32'hFFFFFFF9, 32'd2);
`endif
    // a second start while busy is ignored; done keeps the original schedule and result
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34, 1'b1);
    repeat (5) @(negedge clk);
    b.start = 1'b1;
    b.rs = 32'd7;
    b.rt = 32'd7;
    @(negedge clk);
    b.start = 1'b0;
    check("busy_ignores_start", 32'(b.busy), 32'd1);
    drain(60);
    // flush wins over start in IDLE
    b.start = 1'b1;
    b.flush = 1'b1;
    #1 check("stall_flush_start", 32'(b.stall), 32'd0);
    @(negedge clk);
    b.start = 1'b0;
    b.flush = 1'b0;
    check("flush_beats_start", 32'(b.busy), 32'd0);
    // flush at RUN cycle 10 aborts with no done and HI/LO kept
    issue(2'b00, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (10) @(negedge clk);
    b.flush = 1'b1;
    @(negedge clk);
    b.flush = 1'b0;
    check("flush_busy", 32'(b.busy), 32'd0);
    check("flush_hi", b.hi, m_hi);
    check("flush_lo", b.lo, m_lo);
    repeat (40) @(negedge clk);
    check("flush_idle", 32'(b.busy), 32'd0);
    // reset at RUN cycle 20 clears HI/LO immediately and produces no done
    issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_run_hi", b.hi, 32'd0);
    check("rst_run_lo", b.lo, 32'd0);
    check("rst_run_busy", 32'(b.busy), 32'd0);
    check("rst_run_done", 32'(b.done), 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_run_idle", 32'(b.busy), 32'd0);
    run(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from the EX stage to begin an operation.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs  in  32  operand A (multiplicand or dividend).
- rt  in  32  operand B (multiplier or divisor).
- flush  in  1  pipeline flush; aborts any operation.
- stall  out  1  pipeline stall request.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  error flag, valid while done=1.
- hi  out  32  HI register.
- lo  out  32  LO register.

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, RUN, FIX, DONE.
REQ-004 In IDLE, with start=1 and flush=0, the block SHALL latch rs, rt and op at the clock edge, clear the 5-bit iteration counter and enter RUN.
REQ-005 RUN SHALL last exactly 32 cycles, one shift-add (multiply) or shift-subtract restoring (divide) iteration per cycle, on operand magnitudes; the counter SHALL increment from 0 to 31, then the FSM SHALL enter FIX.
REQ-006 FIX SHALL last 1 cycle and apply sign correction for signed ops:
- MULT: negate the 64-bit product when the operand signs differ.
- DIV: quotient negated when the signs differ; remainder takes the dividend's sign.
REQ-007 On the FIX->DONE edge, hi/lo SHALL be written:
- multiply: hi = product[63:32], lo = product[31:0].
- divide: lo = quotient, hi = remainder.
REQ-008 DONE SHALL last 1 cycle with done=1, then return to IDLE; done therefore rises 34 cycles after the accepting edge.
REQ-009 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-010 stall SHALL be combinational: busy OR (state==IDLE AND start AND NOT flush).
REQ-011 start SHALL be ignored while not in IDLE; a start presented in DONE SHALL NOT be accepted until the following IDLE cycle.
REQ-012 flush=1 in any state SHALL force IDLE at the next edge, leave hi/lo unchanged and suppress done; flush SHALL win over a simultaneous start.
REQ-013 DIVU/DIV with rt==0 SHALL go from IDLE directly to DONE in one cycle, with err=1 and hi/lo unchanged.
REQ-014 DIV with 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 (wrap, no error).
REQ-015 err SHALL be 0 whenever done=0.
REQ-016 hi/lo SHALL change only on the FIX->DONE edge or on reset.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE;
- counter and internal accumulators = 0;
- hi = lo = 0x00000000;
- busy = done = err = 0.
REQ-018 Reset SHALL abort an operation in progress with no done pulse.

Configuration
REQ-019 With macro MULDIV_DIVIDE_EN defined, the block SHALL support all four ops.
REQ-020 Without MULDIV_DIVIDE_EN:
- divide logic SHALL be omitted;
- start with op[1]=1 SHALL go IDLE->DONE in one cycle with err=1, hi/lo unchanged;
- multiply behaviour SHALL be identical to REQ-004..REQ-008.

Verification
REQ-021 MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done 34 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001, err=0.
REQ-022 MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-023 DIVU 100/7 -> lo=14, hi=2; DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-024 DIV rt=0 with hi/lo preloaded to 14/2 -> done the cycle after accept, err=1, hi=2, lo=14 retained; with MULDIV_DIVIDE_EN undefined, DIVU 100/7 -> same one-cycle err=1 response.
REQ-025 Start MULTU, pulse flush at RUN cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged; a second start while busy is not accepted (busy stays on the original schedule).
REQ-026 rst_n low at RUN cycle 20 -> hi=lo=0 and busy=0 before the next clock edge, no done after release.
